// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared sizes, loader state encoding and the NOP word for cpu_mem_responder
package cpu_mem_pkg;
    localparam int WIDTH    = 32;
    localparam int ADDRSIZE = 12;
    localparam logic [0:WIDTH-1] NOP_WORD = 32'h0;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;
endpackage

// File: rtl/mem_ram_2r1w.sv
// mem_ram_2r1w: word array with two asynchronous read ports and one synchronous write port
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr_a/o_rdata_a and i_raddr_b/o_rdata_b read ports.
// Contents are never reset; a same-cycle read of the written address returns the old word.
module mem_ram_2r1w
    import cpu_mem_pkg::*;
(
    input  logic                clk,
    input  logic                i_we,
    input  logic [ADDRSIZE-1:0] i_waddr,
    input  logic [0:WIDTH-1]    i_wdata,
    input  logic [ADDRSIZE-1:0] i_raddr_a,
    output logic [0:WIDTH-1]    o_rdata_a,
    input  logic [ADDRSIZE-1:0] i_raddr_b,
    output logic [0:WIDTH-1]    o_rdata_b
);
    logic [0:WIDTH-1] r_mem [0:(1<<ADDRSIZE)-1];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: unified CPU data/instruction memory with a streaming program loader
// Ports: clk, rst (sync, active high); CPU data port MEM_ADDR/MEM_OUT/MEM_CTRL -> MEM_IN;
// CPU fetch port INS_ADDR -> INS_MEM; loader load_start/load_base/load_valid/load_data/load_last
// -> load_ready, cpu_hold, load_err; access counters acc_rd_cnt/acc_wr_cnt.
// Build option: CPU_MEM_ACC_CNT_EN enables the access counters, otherwise they read 0.
module cpu_mem_responder
    import cpu_mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDRSIZE-1:0] MEM_ADDR,
    input  logic [0:WIDTH-1]    MEM_OUT,
    input  logic                MEM_CTRL,
    output logic [0:WIDTH-1]    MEM_IN,
    input  logic [ADDRSIZE-1:0] INS_ADDR,
    output logic [0:WIDTH-1]    INS_MEM,
    input  logic                load_start,
    input  logic [ADDRSIZE-1:0] load_base,
    input  logic                load_valid,
    input  logic [0:WIDTH-1]    load_data,
    input  logic                load_last,
    output logic                load_ready,
    output logic                cpu_hold,
    output logic                load_err,
    output logic [15:0]         acc_rd_cnt,
    output logic [15:0]         acc_wr_cnt
);
    ld_state_t           r_state, w_next;
    logic [ADDRSIZE-1:0] r_waddr;
    logic                r_err;
    logic                w_cpu_wr, w_ld_wr;
    logic [0:WIDTH-1]    w_ins;
    always_comb begin
        w_next     = r_state;
        w_next     = (r_state == IDLE) ? (load_start ? LOAD : IDLE) :
                     (r_state == LOAD) ? ((load_valid && load_last) ? DONE : LOAD) : IDLE;
        cpu_hold   = r_state != IDLE;
        load_ready = r_state == LOAD;
    end
    assign w_cpu_wr = (r_state == IDLE) && MEM_CTRL;
    assign w_ld_wr  = (r_state == LOAD) && load_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && load_start) begin
                r_waddr <= load_base;
                r_err   <= 1'b0;
            end else if (w_ld_wr) begin
                r_waddr <= r_waddr + 1'b1;
                if (&r_waddr && !load_last) r_err <= 1'b1;
            end
        end
    end
    assign load_err = r_err;
    mem_ram_2r1w u_ram (
        .clk       (clk),
        .i_we      (w_cpu_wr || w_ld_wr),
        .i_waddr   (w_ld_wr ? r_waddr : MEM_ADDR),
        .i_wdata   (w_ld_wr ? load_data : MEM_OUT),
        .i_raddr_a (MEM_ADDR),
        .o_rdata_a (MEM_IN),
        .i_raddr_b (INS_ADDR),
        .o_rdata_b (w_ins)
    );
    assign INS_MEM = cpu_hold ? NOP_WORD : w_ins;
`ifdef CPU_MEM_ACC_CNT_EN
    logic [15:0]         r_rd_cnt, r_wr_cnt;
    logic [ADDRSIZE-1:0] r_prev_addr;
    always_ff @(posedge clk) begin
        r_prev_addr <= MEM_ADDR;
        if (rst) begin
            r_rd_cnt <= 16'd0;
            r_wr_cnt <= 16'd0;
        end else begin
            if (w_cpu_wr && !(&r_wr_cnt)) r_wr_cnt <= r_wr_cnt + 16'd1;
            if ((r_state == IDLE) && !MEM_CTRL && (MEM_ADDR != r_prev_addr) && !(&r_rd_cnt))
                r_rd_cnt <= r_rd_cnt + 16'd1;
        end
    end
    assign acc_rd_cnt = r_rd_cnt;
    assign acc_wr_cnt = r_wr_cnt;
`else
    assign acc_rd_cnt = 16'd0;
    assign acc_wr_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed-vector bench for cpu_mem_responder
module tb_cpu_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] MEM_ADDR, INS_ADDR, load_base;
    logic [0:31] MEM_OUT, MEM_IN, INS_MEM, load_data;
    logic        MEM_CTRL, load_start, load_valid, load_last;
    logic        load_ready, cpu_hold, load_err;
    logic [15:0] acc_rd_cnt, acc_wr_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    cpu_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_OUT    (MEM_OUT),
        .MEM_CTRL   (MEM_CTRL),
        .MEM_IN     (MEM_IN),
        .INS_ADDR   (INS_ADDR),
        .INS_MEM    (INS_MEM),
        .load_start (load_start),
        .load_base  (load_base),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_hold   (cpu_hold),
        .load_err   (load_err),
        .acc_rd_cnt (acc_rd_cnt),
        .acc_wr_cnt (acc_wr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        MEM_ADDR = a;
        INS_ADDR = a;
        #1;
        chk({tag, "_data"}, MEM_IN, exp);
        chk({tag, "_ins"}, INS_MEM, exp);
    endtask

    initial begin
        rst = 1'b1; MEM_ADDR = '0; INS_ADDR = '0; load_base = '0; MEM_OUT = '0; load_data = '0;
        MEM_CTRL = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_hold", cpu_hold, 0);
        chk("rst_ready", load_ready, 0);
        chk("rst_err", load_err, 0);
        chk("rst_rdcnt", acc_rd_cnt, 0);
        chk("rst_wrcnt", acc_wr_cnt, 0);

        MEM_CTRL = 1'b1; MEM_ADDR = 12'h010; MEM_OUT = 32'hDEADBEEF;
        step();
        MEM_CTRL = 1'b0;
        #1 chk("raw", MEM_IN, 32'hDEADBEEF);
        MEM_CTRL = 1'b1; MEM_OUT = 32'hCAFEF00D; INS_ADDR = 12'h010;
        #1 chk("rdw_data", MEM_IN, 32'hDEADBEEF);
        chk("rdw_ins", INS_MEM, 32'hDEADBEEF);
        step();
        MEM_CTRL = 1'b0;
        #1 chk("raw2", MEM_IN, 32'hCAFEF00D);
        MEM_CTRL = 1'b1; MEM_ADDR = 12'h005; MEM_OUT = 32'h55555555;
        step();
        MEM_CTRL = 1'b0;

        load_base = 12'h000; load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("ld_hold", cpu_hold, 1);
        chk("ld_ready", load_ready, 1);
        INS_ADDR = 12'h000;
        #1 chk("ld_nop", INS_MEM, 32'h0);
        MEM_CTRL = 1'b1; MEM_ADDR = 12'h005; MEM_OUT = 32'h00001234;
        load_valid = 1'b1; load_data = 32'h2001_5003;
        step();
        load_data = 32'h3003_0020;
        step();
        load_data = 32'h9000_0000; load_last = 1'b1;
        step();
        load_valid = 1'b0; load_last = 1'b0;
        chk("done_hold", cpu_hold, 1);
        chk("done_ready", load_ready, 0);
        step();
        MEM_CTRL = 1'b0;
        chk("idle_hold", cpu_hold, 0);
        chk("ld_err0", load_err, 0);
        rd_chk("w0", 12'h000, 32'h2001_5003);
        rd_chk("w1", 12'h001, 32'h3003_0020);
        rd_chk("w2", 12'h002, 32'h9000_0000);
        rd_chk("m5", 12'h005, 32'h55555555);

        load_base = 12'hFFE; load_start = 1'b1;
        step();
        load_start = 1'b0; load_valid = 1'b1; load_data = 32'hA1A1_A1A1;
        step();
        load_data = 32'hA2A2_A2A2;
        step();
        load_data = 32'hA3A3_A3A3; load_last = 1'b1;
        step();
        load_valid = 1'b0; load_last = 1'b0;
        chk("wrap_err", load_err, 1);
        step();
        chk("wrap_err_sticky", load_err, 1);
        rd_chk("wfe", 12'hFFE, 32'hA1A1_A1A1);
        rd_chk("wff", 12'hFFF, 32'hA2A2_A2A2);
        rd_chk("w00", 12'h000, 32'hA3A3_A3A3);

        load_base = 12'h100; load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("start_clr_err", load_err, 0);
        load_valid = 1'b1; load_data = 32'hB1B1_B1B1;
        step();
        load_valid = 1'b0; load_last = 1'b1; load_start = 1'b1; load_base = 12'h200;
        step();
        load_last = 1'b0; load_start = 1'b0;
        chk("gap_ready", load_ready, 1);
        load_valid = 1'b1; load_data = 32'hB2B2_B2B2;
        step();
        load_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_hold", cpu_hold, 0);
        chk("abort_ready", load_ready, 0);
        rd_chk("ab0", 12'h100, 32'hB1B1_B1B1);
        rd_chk("ab1", 12'h101, 32'hB2B2_B2B2);

        MEM_ADDR = 12'h000; rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        MEM_CTRL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            MEM_ADDR = 12'h020 + 12'(i); MEM_OUT = 32'h0C00_0000 + i;
            step();
        end
        MEM_CTRL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MEM_ADDR = 12'h030 + 12'(i);
            step();
        end
`ifdef CPU_MEM_ACC_CNT_EN
        chk("acc_wr", acc_wr_cnt, 4);
        chk("acc_rd", acc_rd_cnt, 3);
`else
        chk("acc_wr", acc_wr_cnt, 0);
        chk("acc_rd", acc_rd_cnt, 0);
`endif
        rd_chk("c23", 12'h023, 32'h0C00_0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU's data port (MEM_ADDR/MEM_OUT/MEM_CTRL/MEM_IN) and instruction port (INS_ADDR/INS_MEM).
- Single unified word array, asynchronous reads and synchronous writes, so the CPU's one-cycle fetch/load timing holds.
- Built-in program loader FSM streams words into the array while holding the CPU via cpu_hold.
- Sits beside instruction_set_model in the top level; the loader is fed by the testbench or a UART front end.

Parameters:
- WIDTH, 32, data word width.
- ADDRSIZE, 12, address width; array depth is 1<<ADDRSIZE (4096 words).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- MEM_ADDR  in  12  data address from CPU
- MEM_OUT  in  [0:31]  CPU write data
- MEM_CTRL  in  1  0 = read, 1 = write
- MEM_IN  out  [0:31]  read data to CPU
- INS_ADDR  in  12  instruction fetch address
- INS_MEM  out  [0:31]  instruction word to CPU
- load_start  in  1  one-cycle pulse: begin a program load
- load_base  in  12  first load address, sampled on load_start
- load_valid  in  1  load_data is valid
- load_data  in  [0:31]  program word
- load_last  in  1  qualifies the final word (valid only with load_valid)
- load_ready  out  1  loader accepts a word this cycle
- cpu_hold  out  1  CPU must be held in reset
- load_err  out  1  sticky: address wrapped during a load
- acc_rd_cnt  out  16  data-read counter (optional feature)
- acc_wr_cnt  out  16  data-write counter (optional feature)

Behaviour:
- Reset (rst=1 at posedge):
  - FSM goes to IDLE; cpu_hold=0, load_ready=0, load_err=0, counters=0.
  - Array contents are retained, not cleared.
- Reads: MEM_IN = mem[MEM_ADDR] and INS_MEM = mem[INS_ADDR], combinational with no latency.
- CPU write: when MEM_CTRL=1 and state is IDLE, mem[MEM_ADDR] <= MEM_OUT at posedge. Read-after-write at the same address returns the new data from the next cycle onward.
- Read-during-write in the same cycle returns the old data on both ports.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on load_start. Sample waddr <= load_base; clear load_err.
  - LOAD:
    - cpu_hold=1 and load_ready=1.
    - On load_valid: mem[waddr] <= load_data, waddr <= waddr+1 (mod 4096).
    - If waddr == 4095 on that write and load_last=0, set load_err.
    - On load_valid & load_last, go to DONE.
  - DONE: single cycle; cpu_hold=1, load_ready=0; then go to IDLE.
- Holding cpu_hold through DONE gives the CPU one clean reset cycle after the last word.
- While cpu_hold=1:
  - CPU writes (MEM_CTRL=1) are ignored; the loader has exclusive write access.
  - INS_MEM reads as 32'h0 (NOP).
- load_start in LOAD or DONE is ignored.
- load_last without load_valid is ignored.
- rst during LOAD aborts to IDLE. Words already written stay in the array; waddr is discarded.

Optional Feature:
- Macro CPU_MEM_ACC_CNT_EN.
- Defined:
  - acc_wr_cnt increments on each accepted CPU write.
  - acc_rd_cnt increments each IDLE cycle with MEM_CTRL=0 and MEM_ADDR changed from the previous cycle.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: both outputs are tied to 0 and no counter logic is built.

Decomposition:
- Package cpu_mem_pkg:
  - WIDTH, ADDRSIZE.
  - Loader state encoding IDLE=2'd0, LOAD=2'd1, DONE=2'd2.
  - Constant NOP_WORD=32'h0.
- Sub-module mem_ram_2r1w: the array with two async read ports and one sync write port. Write mux and loader FSM stay in the top.

Test Plan:
- Reset, then MEM_CTRL=1, MEM_ADDR=12'h010, MEM_OUT=32'hDEADBEEF for one cycle, then MEM_CTRL=0 -> MEM_IN=32'hDEADBEEF the next cycle.
- load_start with load_base=0, then three words 32'h2001_5003, 32'h3003_0020, 32'h9000_0000 (last flagged) -> cpu_hold high from the cycle after load_start through DONE; afterwards INS_ADDR=1 gives 32'h3003_0020; load_err=0.
- During LOAD, INS_ADDR=0 -> INS_MEM=0. CPU write MEM_ADDR=5, MEM_OUT=32'h1234 -> mem[5] is unchanged after load.
- load_base=12'hFFE, three words, last on the third -> words land at FFE, FFF, 000; load_err=1.
- load_valid gaps (valid every other cycle), rst asserted after the second word -> FSM returns to IDLE, cpu_hold=0, first two words are present.
- With CPU_MEM_ACC_CNT_EN: 4 writes and 3 distinct-address reads -> acc_wr_cnt=4, acc_rd_cnt=3. Without the macro both read 0.
